param_commit_ctrl: RTL and testbench



---
 rtl/param_pkg.sv | 38 +++
 rtl/frame_counter.sv | 35 +++
 rtl/param_commit_ctrl.sv | 158 +++++++++++++++
 tb/tb_param_commit_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/param_pkg.sv
`default_nettype none
// ============================================================================
// Module : param_pkg
// Brief  : Parameter-set layout, reset defaults and commit FSM states shared
//          by the parameter selector, commit controller and display.
// Rev    : 1.0  initial release
// ============================================================================
package param_pkg;

  localparam int SCALE_CHOICE_W = 2;
  localparam int SCALE_COLOR_W  = 3;
  localparam int MAG_SCALE_W    = 2;

  typedef struct packed {
    logic [SCALE_CHOICE_W-1:0] scale_choice;
    logic [SCALE_COLOR_W-1:0]  scale_color;
    logic [MAG_SCALE_W-1:0]    mag_scale;
    logic                      color;
    logic                      live;
  } param_set_t;

  localparam int         PARAM_SET_W = $bits(param_set_t);
  localparam param_set_t PARAM_RST   = '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FLUSH   = 2'd2,
    SETTLE  = 2'd3
  } commit_state_t;

  // Display mode and musical scale change the FFT/tuner bin layout.
  function automatic logic needs_flush(input param_set_t a, input param_set_t b);
    return (a.live != b.live) || (a.scale_choice != b.scale_choice);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_counter.sv
`default_nettype none
// ============================================================================
// Module : frame_counter
// Brief  : Counts vblank ticks with synchronous clear; hit_o flags the tick
//          that brings the count to terminal_i.
// Rev    : 1.0  initial release
// ============================================================================
module frame_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] terminal_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)       count_d = '0;
    else if (tick_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign hit_o = !clr_i && tick_i && ((count_q + 1'b1) == terminal_i);

endmodule
`default_nettype wire

// File: rtl/param_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module : param_commit_ctrl
// Brief  : Applies staged display parameters atomically at vblank, flushes
//          the FFT pipeline when needed and rate-limits commits.
//          Optional: PARAM_COMMIT_STATS_EN adds commit/flush counters.
// Rev    : 1.0  initial release
// ============================================================================
module param_commit_ctrl
  import param_pkg::*;
#(
  parameter int SETTLE_FRAMES = 2,
  parameter int FLUSH_TIMEOUT = 65535,
  parameter int TO_W          = 16
) (
  input  logic       clk_65mhz,
  input  logic       rst_n,
  input  logic [1:0] stg_scale_choice,
  input  logic [2:0] stg_scale_color,
  input  logic [1:0] stg_mag_scale,
  input  logic       stg_color,
  input  logic       stg_live,
  input  logic       vblank_start,
  input  logic       fft_flush_ack,
  output logic [1:0] act_scale_choice,
  output logic [2:0] act_scale_color,
  output logic [1:0] act_mag_scale,
  output logic       act_color,
  output logic       act_live,
  output logic       commit_pulse,
  output logic       fft_flush_req,
  output logic       pending,
  output logic       flush_err
`ifdef PARAM_COMMIT_STATS_EN
  ,
  output logic [7:0] commit_count,
  output logic [7:0] flush_count
`endif
);

  localparam int              FC_W        = (SETTLE_FRAMES < 2) ? 1 : $clog2(SETTLE_FRAMES + 1);
  localparam logic [FC_W-1:0] SETTLE_TERM = FC_W'(SETTLE_FRAMES);
  localparam logic [TO_W:0]   TO_LIMIT    = (TO_W + 1)'(FLUSH_TIMEOUT);

  commit_state_t   state_q, state_d;
  param_set_t      stg, act_q, act_d;
  logic            commit_q, commit_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            diff, flush_class, to_expired, settle_hit;
  logic            commit_ev, flush_entry, timeout_ev;

  assign stg         = {stg_scale_choice, stg_scale_color, stg_mag_scale, stg_color, stg_live};
  assign diff        = (stg != act_q);
  assign flush_class = needs_flush(stg, act_q);
  assign to_expired  = (({1'b0, to_q} + 1'b1) >= TO_LIMIT);

  frame_counter #(.CNT_W(FC_W)) u_settle_cnt (
    .clk        (clk_65mhz),
    .rst_n      (rst_n),
    .clr_i      (state_q != SETTLE),
    .tick_i     (vblank_start && (state_q == SETTLE)),
    .terminal_i (SETTLE_TERM),
    .hit_o      (settle_hit)
  );

  always_ff @(posedge clk_65mhz or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    commit_ev   = 1'b0;
    flush_entry = 1'b0;
    timeout_ev  = 1'b0;
    case (state_q)
      IDLE:    if (diff) state_d = PENDING;
      PENDING: begin
        if (!diff) begin
          state_d = IDLE;
        end else if (vblank_start) begin
          commit_ev = 1'b1;
          if (flush_class) begin
            flush_entry = 1'b1;
            state_d     = FLUSH;
          end else begin
            state_d = SETTLE;
          end
        end
      end
      // Ack has priority over a coincident timeout.
      FLUSH: begin
        if (fft_flush_ack) begin
          state_d = SETTLE;
        end else if (to_expired) begin
          timeout_ev = 1'b1;
          state_d    = SETTLE;
        end
      end
      SETTLE:  if ((SETTLE_FRAMES == 0) || settle_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending       = (state_q == PENDING);
    fft_flush_req = (state_q == FLUSH);
  end

  always_comb begin
    act_d    = commit_ev ? stg : act_q;
    commit_d = commit_ev;
    err_d    = err_q | timeout_ev;
    to_d     = (state_q == FLUSH) ? (to_q + 1'b1) : '0;
  end

  always_ff @(posedge clk_65mhz or negedge rst_n) begin
    if (!rst_n) begin
      act_q    <= PARAM_RST;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= '0;
    end else begin
      act_q    <= act_d;
      commit_q <= commit_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end

  assign act_scale_choice = act_q.scale_choice;
  assign act_scale_color  = act_q.scale_color;
  assign act_mag_scale    = act_q.mag_scale;
  assign act_color        = act_q.color;
  assign act_live         = act_q.live;
  assign commit_pulse     = commit_q;
  assign flush_err        = err_q;

`ifdef PARAM_COMMIT_STATS_EN
  logic [7:0] commit_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_65mhz or negedge rst_n) begin
    if (!rst_n) begin
      commit_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (commit_q && (commit_cnt_q != 8'hFF))   commit_cnt_q <= commit_cnt_q + 8'd1;
      if (flush_entry && (flush_cnt_q != 8'hFF)) flush_cnt_q  <= flush_cnt_q + 8'd1;
    end
  end

  assign commit_count = commit_cnt_q;
  assign flush_count  = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_param_commit_ctrl
// Brief  : Directed vector table, hand sequences and randomized run against
//          a behavioural model of param_commit_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
module tb_param_commit_ctrl;

  localparam int SF = 2;
  localparam int TO = 100;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] stg   = '0;
  logic       vb    = 1'b0;
  logic       ack   = 1'b0;

  logic [1:0] act_scale_choice;
  logic [2:0] act_scale_color;
  logic [1:0] act_mag_scale;
  logic       act_color, act_live;
  logic       commit_pulse, fft_flush_req, pending, flush_err;
`ifdef PARAM_COMMIT_STATS_EN
  logic [7:0] commit_count, flush_count;
`endif

  wire [8:0] act = {act_scale_choice, act_scale_color, act_mag_scale, act_color, act_live};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_commit_ctrl #(.SETTLE_FRAMES(SF), .FLUSH_TIMEOUT(TO), .TO_W(16)) dut (
    .clk_65mhz        (clk),
    .rst_n            (rst_n),
    .stg_scale_choice (stg[8:7]),
    .stg_scale_color  (stg[6:4]),
    .stg_mag_scale    (stg[3:2]),
    .stg_color        (stg[1]),
    .stg_live         (stg[0]),
    .vblank_start     (vb),
    .fft_flush_ack    (ack),
    .act_scale_choice (act_scale_choice),
    .act_scale_color  (act_scale_color),
    .act_mag_scale    (act_mag_scale),
    .act_color        (act_color),
    .act_live         (act_live),
    .commit_pulse     (commit_pulse),
    .fft_flush_req    (fft_flush_req),
    .pending          (pending),
    .flush_err        (flush_err)
`ifdef PARAM_COMMIT_STATS_EN
    ,
    .commit_count     (commit_count),
    .flush_count      (flush_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {pending, flush_req, commit_pulse, flush_err, act[8:0]}
  function automatic logic [12:0] obs();
    return {pending, fft_flush_req, commit_pulse, flush_err, act};
  endfunction

  function automatic logic [12:0] mk(input bit p, input bit r, input bit c, input bit e,
                                     input logic [8:0] a);
    return {p, r, c, e, a};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; stg = '0; vb = 1'b0; ack = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Behavioural reference: tracks what the user has committed and how long
  // each post-commit phase still has to run.
  logic [8:0] m_act;
  bit         m_pend, m_flush, m_settle, m_pulse, m_err;
  int         m_fcyc, m_svb;

  task automatic model_clear();
    m_act = '0; m_pend = 0; m_flush = 0; m_settle = 0; m_pulse = 0; m_err = 0;
    m_fcyc = 0; m_svb = 0;
  endtask

  task automatic model_step(input logic [8:0] s, input bit v, input bit a);
    bit fc;
    fc = (s[0] != m_act[0]) || (s[8:7] != m_act[8:7]);
    m_pulse = 0;
    if (m_flush) begin
      m_fcyc++;
      if (a || m_fcyc == TO) begin
        if (!a) m_err = 1;
        m_flush = 0; m_settle = 1; m_svb = 0;
      end
    end else if (m_settle) begin
      if (v) m_svb++;
      if (SF == 0 || m_svb == SF) m_settle = 0;
    end else if (m_pend) begin
      if (s == m_act) m_pend = 0;
      else if (v) begin
        m_act = s; m_pulse = 1; m_pend = 0;
        if (fc) begin m_flush = 1; m_fcyc = 0; end
        else begin m_settle = 1; m_svb = 0; end
      end
    end else if (s != m_act) begin
      m_pend = 1;
    end
  endtask

  typedef struct {
    logic [8:0]  stg;
    logic        vb;
    logic        ack;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int n;
    int r;

    tbl[0]  = '{9'h008, 1'b0, 1'b0, mk(1, 0, 0, 0, 9'h000)};
    tbl[1]  = '{9'h008, 1'b1, 1'b0, mk(0, 0, 1, 0, 9'h008)};
    tbl[2]  = '{9'h008, 1'b0, 1'b0, mk(0, 0, 0, 0, 9'h008)};
    tbl[3]  = '{9'h008, 1'b1, 1'b0, mk(0, 0, 0, 0, 9'h008)};
    tbl[4]  = '{9'h008, 1'b1, 1'b0, mk(0, 0, 0, 0, 9'h008)};
    tbl[5]  = '{9'h009, 1'b1, 1'b0, mk(1, 0, 0, 0, 9'h008)};
    tbl[6]  = '{9'h009, 1'b0, 1'b0, mk(1, 0, 0, 0, 9'h008)};
    tbl[7]  = '{9'h009, 1'b1, 1'b0, mk(0, 1, 1, 0, 9'h009)};
    tbl[8]  = '{9'h009, 1'b0, 1'b0, mk(0, 1, 0, 0, 9'h009)};
    tbl[9]  = '{9'h009, 1'b0, 1'b1, mk(0, 0, 0, 0, 9'h009)};
    tbl[10] = '{9'h00B, 1'b1, 1'b0, mk(0, 0, 0, 0, 9'h009)};
    tbl[11] = '{9'h00B, 1'b1, 1'b0, mk(0, 0, 0, 0, 9'h009)};
    tbl[12] = '{9'h00B, 1'b1, 1'b0, mk(1, 0, 0, 0, 9'h009)};
    tbl[13] = '{9'h009, 1'b0, 1'b0, mk(0, 0, 0, 0, 9'h009)};
    tbl[14] = '{9'h009, 1'b1, 1'b0, mk(0, 0, 0, 0, 9'h009)};

    do_reset();
    check("reset", obs(), 13'h0);

    for (int i = 0; i < 15; i++) begin
      stg = tbl[i].stg; vb = tbl[i].vb; ack = tbl[i].ack;
      step();
      check($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end

    // Flush with no ack: times out after TO cycles, error is sticky.
    stg = 9'h089; vb = 1'b0; ack = 1'b0;
    step();
    vb = 1'b1;
    step();
    check("to_req", fft_flush_req, 1);
    vb = 1'b0;
    n = 0;
    while (fft_flush_req && n < 200) begin
      step();
      n++;
    end
    check("to_len", n, TO);
    check("to_err", flush_err, 1);
    vb = 1'b1;
    step();
    step();
    check("to_idle", obs(), mk(0, 0, 0, 1, 9'h089));
    stg = 9'h08D; vb = 1'b0;
    step();
    vb = 1'b1;
    step();
    check("err_sticky", obs(), mk(0, 0, 1, 1, 9'h08D));
    step();
    step();

    // Asynchronous reset in the middle of a flush.
    stg = 9'h08C; vb = 1'b0;
    step();
    vb = 1'b1;
    step();
    vb = 1'b0;
    step();
    check("pre_rst_req", fft_flush_req, 1);
    rst_n = 1'b0;
    #2;
    check("async_rst", obs(), 13'h0);
    step();
    rst_n = 1'b1;

    // Randomized run against the model.
    do_reset();
    model_clear();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       stg = 9'($urandom);
      else if (r < 11) stg = m_act;
      vb  = ($urandom_range(0, 5) == 0);
      ack = ($urandom_range(0, 24) == 0);
      model_step(stg, vb, ack);
      step();
      check("rand", obs(), mk(m_pend, m_flush, m_pulse, m_err, m_act));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
